// File: rtl/rv32i_cpu_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rv32i_cpu_core                                             |
// | Description : Single-cycle RV32I integer core. One instruction is        |
// |               fetched and fully executed per clock.                      |
// | Ports       : clk, reset            - clock, synchronous active-high rst |
// |               inst_addr / inst_val  - combinational instruction port     |
// |               data_addr / data_rd   - combinational data read port       |
// |               data_wr / data_wr_en  - store data and byte-lane strobes   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rv32i_cpu_core (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_val,
  output logic [31:0] data_addr,
  input  logic [31:0] data_rd,
  output logic [31:0] data_wr,
  output logic [3:0]  data_wr_en
);

  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_F7_BASE    = 7'b0000000;
  localparam logic [6:0] C_F7_ALT     = 7'b0100000;

  // Architectural state
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] rf_q [32];

  // Instruction fields
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  // Decoded instruction classes; anything left unset executes as a NOP
  logic w_is_lui;
  logic w_is_auipc;
  logic w_is_jal;
  logic w_is_jalr;
  logic w_is_branch;
  logic w_is_load;
  logic w_is_store;
  logic w_is_opimm;
  logic w_is_op;

  // Datapath
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_alu_b;
  logic        w_alu_alt;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_res;
  logic [31:0] w_sum_i;
  logic [31:0] w_agen;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_result;
  logic        w_br_taken;
  logic [1:0]  w_off;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_val;
  logic        w_rf_we;
  logic [31:0] w_rf_wdata;

  assign w_opcode = inst_val[6:0];
  assign w_rd     = inst_val[11:7];
  assign w_f3     = inst_val[14:12];
  assign w_rs1    = inst_val[19:15];
  assign w_rs2    = inst_val[24:20];
  assign w_f7     = inst_val[31:25];

  assign w_imm_i = {{20{inst_val[31]}}, inst_val[31:20]};
  assign w_imm_s = {{20{inst_val[31]}}, inst_val[31:25], inst_val[11:7]};
  assign w_imm_b = {{19{inst_val[31]}}, inst_val[31], inst_val[7],
                    inst_val[30:25], inst_val[11:8], 1'b0};
  assign w_imm_u = {inst_val[31:12], 12'h000};
  assign w_imm_j = {{11{inst_val[31]}}, inst_val[31], inst_val[19:12],
                    inst_val[20], inst_val[30:21], 1'b0};

  // Decode with funct-field validation so reserved encodings fall to NOP
  always_comb begin
    w_is_lui    = (w_opcode == C_OPC_LUI);
    w_is_auipc  = (w_opcode == C_OPC_AUIPC);
    w_is_jal    = (w_opcode == C_OPC_JAL);
    w_is_jalr   = (w_opcode == C_OPC_JALR) && (w_f3 == 3'b000);
    w_is_branch = (w_opcode == C_OPC_BRANCH) && (w_f3 != 3'b010) && (w_f3 != 3'b011);
    w_is_load   = (w_opcode == C_OPC_LOAD) &&
                  ((w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                   (w_f3 == 3'b100) || (w_f3 == 3'b101));
    w_is_store  = (w_opcode == C_OPC_STORE) &&
                  ((w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010));
    w_is_opimm  = 1'b0;
    if (w_opcode == C_OPC_OPIMM) begin
      case (w_f3)
        3'b001:  w_is_opimm = (w_f7 == C_F7_BASE);
        3'b101:  w_is_opimm = (w_f7 == C_F7_BASE) || (w_f7 == C_F7_ALT);
        default: w_is_opimm = 1'b1;
      endcase
    end
    w_is_op = (w_opcode == C_OPC_OP) &&
              ((w_f7 == C_F7_BASE) ||
               ((w_f7 == C_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
  end

  // Register file read; x0 is hard-wired to zero
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'h0 : rf_q[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'h0 : rf_q[w_rs2];

  // ALU: second operand is rs2 for OP, otherwise the I-immediate
  assign w_alu_b   = w_is_op ? w_rs2_val : w_imm_i;
  assign w_shamt   = w_alu_b[4:0];
  // funct7[5] selects SUB only for register ops; for SRAI/SRA it selects arithmetic shift
  assign w_alu_alt = (w_is_op && w_f7[5]) ||
                     (w_is_opimm && (w_f3 == 3'b101) && w_f7[5]);

  always_comb begin
    w_alu_res = 32'h0;
    case (w_f3)
      3'b000:  w_alu_res = (w_is_op && w_alu_alt) ? (w_rs1_val - w_alu_b)
                                                  : (w_rs1_val + w_alu_b);
      3'b001:  w_alu_res = w_rs1_val << w_shamt;
      3'b010:  w_alu_res = {31'h0, ($signed(w_rs1_val) < $signed(w_alu_b))};
      3'b011:  w_alu_res = {31'h0, (w_rs1_val < w_alu_b)};
      3'b100:  w_alu_res = w_rs1_val ^ w_alu_b;
      3'b101:  w_alu_res = w_alu_alt ? ($signed(w_rs1_val) >>> w_shamt)
                                     : (w_rs1_val >> w_shamt);
      3'b110:  w_alu_res = w_rs1_val | w_alu_b;
      default: w_alu_res = w_rs1_val & w_alu_b;
    endcase
  end

  // Address generation shared by loads, stores and the JALR target
  assign w_sum_i    = w_rs1_val + w_imm_i;
  assign w_agen     = w_is_store ? (w_rs1_val + w_imm_s) : w_sum_i;
  assign w_pc_plus4 = pc_q + 32'd4;

  always_comb begin
    w_result = w_alu_res;
    if (w_is_lui)                    w_result = w_imm_u;
    else if (w_is_auipc)             w_result = pc_q + w_imm_u;
    else if (w_is_load || w_is_store) w_result = w_agen;
  end

  assign data_addr = w_result;
  assign w_off     = w_agen[1:0];

  // Branch comparison
  always_comb begin
    case (w_f3)
      3'b000:  w_br_taken = (w_rs1_val == w_rs2_val);
      3'b001:  w_br_taken = (w_rs1_val != w_rs2_val);
      3'b100:  w_br_taken = ($signed(w_rs1_val) < $signed(w_rs2_val));
      3'b101:  w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'b110:  w_br_taken = (w_rs1_val < w_rs2_val);
      default: w_br_taken = (w_rs1_val >= w_rs2_val);
    endcase
  end

  // Next PC
  always_comb begin
    pc_d = w_pc_plus4;
    if (w_is_jal)                       pc_d = pc_q + w_imm_j;
    else if (w_is_jalr)                 pc_d = {w_sum_i[31:1], 1'b0};
    else if (w_is_branch && w_br_taken) pc_d = pc_q + w_imm_b;
  end

  // Load lane select; a halfword at offset 3 only has byte 3 available
  always_comb begin
    case (w_off)
      2'd0: begin w_ld_byte = data_rd[7:0];   w_ld_half = data_rd[15:0];           end
      2'd1: begin w_ld_byte = data_rd[15:8];  w_ld_half = data_rd[23:8];           end
      2'd2: begin w_ld_byte = data_rd[23:16]; w_ld_half = data_rd[31:16];          end
      default: begin w_ld_byte = data_rd[31:24]; w_ld_half = {8'h00, data_rd[31:24]}; end
    endcase
  end

  always_comb begin
    case (w_f3)
      3'b000:  w_ld_val = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_val = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_val = {24'h0, w_ld_byte};
      3'b101:  w_ld_val = {16'h0, w_ld_half};
      default: w_ld_val = data_rd;
    endcase
  end

  // Store lanes; strobes shifted past bit 3 are simply dropped
  always_comb begin
    data_wr    = (w_f3 == 3'b010) ? w_rs2_val : (w_rs2_val << {w_off, 3'b000});
    data_wr_en = 4'b0000;
    if (w_is_store && !reset) begin
      case (w_f3)
        3'b000:  data_wr_en = 4'b0001 << w_off;
        3'b001:  data_wr_en = 4'b0011 << w_off;
        default: data_wr_en = 4'b1111;
      endcase
    end
  end

  // Writeback
  always_comb begin
    w_rf_we = (w_is_lui || w_is_auipc || w_is_jal || w_is_jalr ||
               w_is_load || w_is_opimm || w_is_op) && (w_rd != 5'd0);
    if (w_is_jal || w_is_jalr) w_rf_wdata = w_pc_plus4;
    else if (w_is_load)        w_rf_wdata = w_ld_val;
    else                       w_rf_wdata = w_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 32'h0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'h0;
      end
    end else begin
      pc_q <= pc_d;
      if (w_rf_we) begin
        rf_q[w_rd] <= w_rf_wdata;
      end
    end
  end

  assign inst_addr = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_cpu_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rv32i_cpu_core                                          |
// | Description : Directed self-checking bench for rv32i_cpu_core. Register  |
// |               contents are observed through data_addr by briefly        |
// |               presenting ADDI x0,xN,0 between clock edges.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rv32i_cpu_core;

  localparam logic [6:0] C_OPIMM = 7'b0010011;
  localparam logic [6:0] C_LOAD  = 7'b0000011;
  localparam logic [6:0] C_LUI   = 7'b0110111;
  localparam logic [6:0] C_JALR  = 7'b1100111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic [31:0] inst_val;
  logic [31:0] data_addr;
  logic [31:0] data_rd;
  logic [31:0] data_wr;
  logic [3:0]  data_wr_en;

  int n_cmp = 0;
  int n_err = 0;

  rv32i_cpu_core dut (
    .clk        (clk),
    .reset      (reset),
    .inst_addr  (inst_addr),
    .inst_val   (inst_val),
    .data_addr  (data_addr),
    .data_rd    (data_rd),
    .data_wr    (data_wr),
    .data_wr_en (data_wr_en)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins);
    inst_val = ins;
    #1;
  endtask

  // Reads register r combinationally: ADDI x0,r,0 makes data_addr equal r
  task automatic probe(input logic [4:0] r, input logic [31:0] exp, input string tag);
    drive(enc_i(32'd0, r, 3'b000, 5'd0, C_OPIMM));
    chk(tag, data_addr, exp);
  endtask

  initial begin
    reset   = 1'b1;
    data_rd = 32'h0;
    // A store presented during reset must not strobe
    drive(enc_s(32'd0, 5'd4, 5'd3, 3'b010));
    chk("rst_wr_en", {28'h0, data_wr_en}, 32'h0);
    tick();
    reset = 1'b0;
    chk("rst_pc", inst_addr, 32'h0);
    probe(5'd1, 32'h0, "rst_x1");

    // ADDI x1,x0,5 ; ADDI x2,x1,-7
    drive(enc_i(32'd5, 5'd0, 3'b000, 5'd1, C_OPIMM));
    chk("addi1_alu", data_addr, 32'h5);
    tick();
    chk("pc4", inst_addr, 32'h4);
    drive(enc_i(-32'sd7, 5'd1, 3'b000, 5'd2, C_OPIMM));
    chk("addi2_alu", data_addr, 32'hFFFF_FFFE);
    tick();
    chk("pc8", inst_addr, 32'h8);
    probe(5'd1, 32'h5, "x1_eq5");
    probe(5'd2, 32'hFFFF_FFFE, "x2_neg2");

    // LUI x3,0x20000 ; ADDI x4,x0,0xA ; SW x4,0(x3)
    drive({20'h20000, 5'd3, C_LUI});
    tick();
    drive(enc_i(32'hA, 5'd0, 3'b000, 5'd4, C_OPIMM));
    tick();
    drive(enc_s(32'd0, 5'd4, 5'd3, 3'b010));
    chk("sw_addr", data_addr, 32'h2000_0000);
    chk("sw_data", data_wr, 32'h0000_000A);
    chk("sw_en", {28'h0, data_wr_en}, 32'hF);
    tick();

    // x5 = 0x123456AB, x6 = 0x10000000, SB x5,2(x6)
    drive({20'h12345, 5'd5, C_LUI});
    tick();
    drive(enc_i(32'h6AB, 5'd5, 3'b000, 5'd5, C_OPIMM));
    tick();
    drive({20'h10000, 5'd6, C_LUI});
    tick();
    drive(enc_s(32'd2, 5'd5, 5'd6, 3'b000));
    chk("sb_addr", data_addr, 32'h1000_0002);
    chk("sb_en", {28'h0, data_wr_en}, 32'h4);
    chk("sb_lane", data_wr & 32'h00FF_0000, 32'h00AB_0000);
    tick();

    // LB x7,2(x6) ; LBU x8,2(x6) with data_rd = 0x00AB0000
    data_rd = 32'h00AB_0000;
    drive(enc_i(32'd2, 5'd6, 3'b000, 5'd7, C_LOAD));
    tick();
    drive(enc_i(32'd2, 5'd6, 3'b100, 5'd8, C_LOAD));
    tick();
    probe(5'd7, 32'hFFFF_FFAB, "lb_sext");
    probe(5'd8, 32'h0000_00AB, "lbu_zext");

    // SH at offset 3: strobe truncated to lane 3, data shifted by 24
    drive(enc_s(32'd3, 5'd5, 5'd6, 3'b001));
    chk("sh3_en", {28'h0, data_wr_en}, 32'h8);
    chk("sh3_data", data_wr, 32'hAB00_0000);
    tick();
    // LH at offset 3: only byte 3 (0x80) in [7:0], zeros above, then sign-extend bit 15
    data_rd = 32'h8000_0000;
    drive(enc_i(32'd3, 5'd6, 3'b001, 5'd9, C_LOAD));
    tick();
    data_rd = 32'h0;
    probe(5'd9, 32'h0000_0080, "lh3");
    chk("pc52", inst_addr, 32'd52);

    // Branches: x10=-1, x11=1
    drive(enc_i(-32'sd1, 5'd0, 3'b000, 5'd10, C_OPIMM));
    tick();
    drive(enc_i(32'd1, 5'd0, 3'b000, 5'd11, C_OPIMM));
    tick();
    drive(enc_b(32'd8, 5'd11, 5'd10, 3'b100));   // BLT at 60
    tick();
    chk("blt_taken", inst_addr, 32'd68);
    drive(enc_b(32'd8, 5'd11, 5'd10, 3'b110));   // BLTU at 68
    tick();
    chk("bltu_not", inst_addr, 32'd72);

    // JAL x1,+16 at 72 ; JALR x0,x1,3
    drive(enc_j(32'd16, 5'd1));
    tick();
    chk("jal_pc", inst_addr, 32'd88);
    probe(5'd1, 32'd76, "jal_link");
    drive(enc_i(32'd3, 5'd1, 3'b000, 5'd0, C_JALR));
    tick();
    chk("jalr_pc", inst_addr, 32'h4E);

    // Write to x0, then unknown opcode, then ECALL
    drive(enc_i(32'd123, 5'd0, 3'b000, 5'd0, C_OPIMM));
    tick();
    probe(5'd0, 32'h0, "x0_zero");
    drive(32'hFFFF_FFFF);
    chk("unk_en", {28'h0, data_wr_en}, 32'h0);
    tick();
    chk("unk_pc", inst_addr, 32'h56);
    probe(5'd11, 32'h1, "unk_nowr");
    drive(32'h0000_0073);
    tick();
    chk("ecall_pc", inst_addr, 32'h5A);

    // Mid-program reset with a store presented
    reset = 1'b1;
    drive(enc_s(32'd0, 5'd4, 5'd3, 3'b010));
    chk("mid_rst_en", {28'h0, data_wr_en}, 32'h0);
    tick();
    reset = 1'b0;
    chk("mid_rst_pc", inst_addr, 32'h0);
    probe(5'd1, 32'h0, "mid_rst_x1");
    probe(5'd5, 32'h0, "mid_rst_x5");
    probe(5'd10, 32'h0, "mid_rst_x10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
